// File: rtl/shock_alarm_controller.sv
// Shock burst alarm: qualifies BURST_COUNT shock edges within a WINDOW_CYCLES window,
// holds alarm until acknowledged, then locks out for COOLDOWN_CYCLES. Optional SHOCK_TIMESTAMP_EN.
module shock_alarm_controller #(
    parameter int WINDOW_CYCLES   = 64,
    parameter int BURST_COUNT     = 3,
    parameter int COOLDOWN_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        shock_in,
    input  logic        alarm_ack,
    output logic        alarm,
    output logic [1:0]  state,
`ifdef SHOCK_TIMESTAMP_EN
    output logic [15:0] alarm_ts,
`endif
    output logic [7:0]  shock_total
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WINDOW   = 2'd1,
        ALARM    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW_CYCLES - 1);
    localparam logic [3:0] BURST_TGT = 4'(BURST_COUNT);
    localparam logic [7:0] CD_LAST   = (COOLDOWN_CYCLES == 0) ? 8'd0 : 8'(COOLDOWN_CYCLES - 1);

    state_t     st;
    logic       shock_prev;
    logic       shock_evt;
    logic [3:0] burst_cnt;
    logic [3:0] burst_inc;
    logic [7:0] win_cnt;
    logic [7:0] cd_cnt;
    logic       enter_alarm;

    assign state     = st;
    assign shock_evt = shock_in & ~shock_prev;
    assign burst_inc = burst_cnt + 4'd1;

    // Qualification wins over the window timeout, even on the last window cycle.
    always_comb begin
        enter_alarm = 1'b0;
        if (shock_evt) begin
            if (st == IDLE && BURST_COUNT == 1)
                enter_alarm = 1'b1;
            else if (st == WINDOW && burst_inc == BURST_TGT)
                enter_alarm = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            alarm       <= 1'b0;
            shock_total <= 8'd0;
            shock_prev  <= 1'b0;
            burst_cnt   <= 4'd0;
            win_cnt     <= 8'd0;
            cd_cnt      <= 8'd0;
        end else begin
            shock_prev <= shock_in;
            if (shock_evt && shock_total != 8'hFF)
                shock_total <= shock_total + 8'd1;

            if (enter_alarm) begin
                st        <= ALARM;
                alarm     <= 1'b1;
                burst_cnt <= 4'd0;
                win_cnt   <= 8'd0;
            end else begin
                case (st)
                    IDLE: begin
                        if (shock_evt) begin
                            st        <= WINDOW;
                            burst_cnt <= 4'd1;
                            win_cnt   <= 8'd1;
                        end
                    end
                    WINDOW: begin
                        if (win_cnt == WIN_LAST) begin
                            st        <= IDLE;
                            burst_cnt <= 4'd0;
                            win_cnt   <= 8'd0;
                        end else begin
                            win_cnt <= win_cnt + 8'd1;
                            if (shock_evt)
                                burst_cnt <= burst_inc;
                        end
                    end
                    ALARM: begin
                        burst_cnt <= 4'd0;
                        win_cnt   <= 8'd0;
                        if (alarm_ack) begin
                            alarm  <= 1'b0;
                            cd_cnt <= 8'd0;
                            st     <= (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
                        end
                    end
                    COOLDOWN: begin
                        burst_cnt <= 4'd0;
                        win_cnt   <= 8'd0;
                        if (cd_cnt == CD_LAST) begin
                            st     <= IDLE;
                            cd_cnt <= 8'd0;
                        end else begin
                            cd_cnt <= cd_cnt + 8'd1;
                        end
                    end
                    default: begin
                        st    <= IDLE;
                        alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SHOCK_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    // alarm_ts holds the counter value sampled on the edge that enters ALARM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt   <= 16'd0;
            alarm_ts <= 16'd0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (enter_alarm)
                alarm_ts <= ts_cnt;
        end
    end
`endif

endmodule
